gate_pipeline: RTL

- Parametrised, handshaked successor to the fixed 1-bit register/OR/AND/NOT/register/XOR example netlist.
- Operands are WIDTH bits wide, and the delay register chain is DEPTH stages long.
- The gate function is selectable per transaction.
- Sits in the examples/regression set of the violating-paths flow as a timing-clean, stallable datapath with register-to-register paths of known length.

---
 rtl/gate_pipeline_pkg.sv | 26 ++
 rtl/gate_pipeline_stage.sv | 36 +++
 rtl/gate_pipeline.sv | 109 ++++++++++
 3 files changed

// File: rtl/gate_pipeline_pkg.sv
// gate_pipeline_pkg
//   Shared definitions for the gate_pipeline datapath:
//   - mode_e   : gate-function select carried with every transaction
//   - gate_bit : single-bit gate function; the top applies it across WIDTH
package gate_pipeline_pkg;

  typedef enum logic [1:0] {
    MODE_OR_AND  = 2'd0,  // ~((x | y) & z)
    MODE_AND_OR  = 2'd1,  // ~((x & y) | z)
    MODE_XOR_AND = 2'd2,  // ~((x ^ y) & z)
    MODE_PASS    = 2'd3   // x
  } mode_e;

  // The function is written per bit so it is independent of the operand width.
  function automatic logic gate_bit(mode_e mode, logic x, logic y, logic z);
    logic b;
    case (mode)
      MODE_OR_AND:  b = ~((x | y) & z);
      MODE_AND_OR:  b = ~((x & y) | z);
      MODE_XOR_AND: b = ~((x ^ y) & z);
      default:      b = x;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gate_pipeline_stage.sv
// gate_pipe_stage
//   One delay slice of the gate pipeline: registers {valid, b, d}.
//   Loads from its predecessor when en=1 and holds otherwise.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               global pipeline enable
//   d_valid/d_b/d_d  predecessor valid, gate result and XOR operand
//   q_valid/q_b/q_d  registered copies
module gate_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_b,
  input  logic [WIDTH-1:0] d_d,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] q_d
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_b     <= '0;
      q_d     <= '0;
    end else if (en) begin
      // Bubbles shift like real data so they are never collapsed.
      q_valid <= d_valid;
      q_b     <= d_b;
      q_d     <= d_d;
    end
  end

endmodule

// File: rtl/gate_pipeline.sv
// gate_pipeline
//   Stallable, handshaked gate datapath. Stage 0 captures all operands and
//   the mode; the logic stage computes b from the stage-0 registers; DEPTH
//   delay slices carry {valid, b, in4}. Total latency S = DEPTH+1 cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready = global enable)
//   in1..in3, mode        gate operands and function select
//   in4                   XOR operand for out1
//   out_valid / out_ready output handshake
//   out1 = in4 ^ b, out2 = b (from the last slice)
//   tx_count              completed output transfers, wraps silently
module gate_pipeline
  import gate_pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [CNT_W-1:0] tx_count
);

  logic             en;
  logic             valid0_reg;
  logic [WIDTH-1:0] x_reg, y_reg, z_reg, d_reg;
  mode_e            mode_reg;
  logic [WIDTH-1:0] b_logic;
  logic [CNT_W-1:0] tx_count_reg;

  // Index 0 is the logic-stage output feeding the first slice;
  // index DEPTH is the last slice, which drives the outputs.
  logic [DEPTH:0]            valid_chain;
  logic [DEPTH:0][WIDTH-1:0] b_chain;
  logic [DEPTH:0][WIDTH-1:0] d_chain;

  // The whole pipeline advances unless a valid result is being held back.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 0: every operand is registered, none bypasses this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_reg <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      d_reg      <= '0;
      mode_reg   <= MODE_OR_AND;
    end else if (en) begin
      valid0_reg <= in_valid;
      x_reg      <= in1;
      y_reg      <= in2;
      z_reg      <= in3;
      d_reg      <= in4;
      mode_reg   <= mode_e'(mode);
    end
  end

  // Logic stage: bitwise gate function from the stage-0 registers.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign b_logic[gi] = gate_bit(mode_reg, x_reg[gi], y_reg[gi], z_reg[gi]);
  end

  assign valid_chain[0] = valid0_reg;
  assign b_chain[0]     = b_logic;
  assign d_chain[0]     = d_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    gate_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .d_valid (valid_chain[gi]),
      .d_b     (b_chain[gi]),
      .d_d     (d_chain[gi]),
      .q_valid (valid_chain[gi+1]),
      .q_b     (b_chain[gi+1]),
      .q_d     (d_chain[gi+1])
    );
  end

  assign out_valid = valid_chain[DEPTH];
  assign out2      = b_chain[DEPTH];
  assign out1      = d_chain[DEPTH] ^ b_chain[DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count_reg <= '0;
    end else if (out_valid && out_ready) begin
      tx_count_reg <= tx_count_reg + CNT_W'(1);
    end
  end

  assign tx_count = tx_count_reg;

endmodule
